fifo_read_port: RTL and testbench

Read-side controller for the team's synchronous FIFO. It watches the writer's pointer and issues reads to the FIFO's 1-cycle-latency synchronous RAM. It buffers returned words in a 2-entry output queue and presents them on a valid/ready stream. It is the consumer end of the pointer interface whose write side advances wr_ptr.

---
 rtl/fifo_read_port.sv | 88 ++++++++
 tb/tb_fifo_read_port.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_port.sv
// Read-side controller for the synchronous FIFO: issues RAM reads against
// the writer's pointer and streams returned words through a 2-entry queue.
module fifo_read_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W+1:0] avail
);

    logic [1:0]        buf_cnt;
    logic              inflight;
    logic [DATA_W-1:0] tail;
    logic              empty;
    logic              pop;
    logic [1:0]        occ;
    logic [ADDR_W:0]   diff;

    assign empty     = (wr_ptr == rd_ptr);
    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid && out_ready;

    // Queue slots still claimed once this cycle's pop leaves; never underflows
    // because pop implies buf_cnt >= 1.
    assign occ = buf_cnt + {1'b0, inflight} - {1'b0, pop};

    assign mem_ren   = !rst && !empty && !flush && (occ < 2'd2);
    assign mem_raddr = rd_ptr[ADDR_W-1:0];

    assign diff  = wr_ptr - rd_ptr;
    assign avail = {1'b0, diff}
                 + (ADDR_W+2)'(inflight)
                 + (ADDR_W+2)'(buf_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
            out_data <= '0;
            tail     <= '0;
        end else if (flush) begin
            // Returning read data is dropped by clearing inflight.
            rd_ptr   <= wr_ptr;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_ren;
            buf_cnt  <= occ;
            if (mem_ren) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
            unique case ({inflight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        out_data <= mem_rdata;
                    end else begin
                        tail <= mem_rdata;
                    end
                end
                2'b01: begin
                    out_data <= tail;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        out_data <= mem_rdata;
                    end else begin
                        out_data <= tail;
                        tail     <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_port.sv
// Bench for fifo_read_port: vector table for reset/latency, scoreboard for
// streaming, backpressure, pointer wrap, flush and reset-over-flush.
module tb_fifo_read_port;

    logic        clk;
    logic        rst;
    logic [4:0]  wr_ptr;
    logic [4:0]  rd_ptr;
    logic        mem_ren;
    logic [3:0]  mem_raddr;
    logic [15:0] mem_rdata;
    logic        flush;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  avail;

    fifo_read_port #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .avail     (avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram [16];

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    typedef struct {
        logic        rst;
        logic [4:0]  wr;
        logic        rdy;
        logic        chk;
        logic        ren;
        logic [3:0]  raddr;
        logic        vld;
        logic [15:0] data;
        logic [4:0]  rd;
        logic [5:0]  av;
    } vec_t;

    vec_t        tbl [7];
    int          total;
    int          passed;
    int          cyc;
    int          pops;
    int          first_pop;
    int          last_pop;
    int          ren_cnt;
    int          bad;
    logic [15:0] sb [$];
    logic [3:0]  raddr_log [$];
    logic [4:0]  rdp_log [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic write_word(input logic [15:0] d);
        ram[wr_ptr[3:0]] = d;
        sb.push_back(d);
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic tick();
        logic [15:0] e;
        #1;
        if (mem_ren) begin
            ren_cnt++;
            raddr_log.push_back(mem_raddr);
            rdp_log.push_back(rd_ptr);
            chk("ren_nonempty", 32'(wr_ptr != rd_ptr), 32'd1);
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL extra_word: got %0h expected none", out_data);
            end else begin
                e = sb.pop_front();
                chk("pop_data", 32'(out_data), 32'(e));
                if (pops == 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        total = 0; passed = 0; cyc = 0; pops = 0;
        first_pop = 0; last_pop = 0; ren_cnt = 0; bad = 0;
        rst = 1'b1; wr_ptr = 5'd0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) ram[i] = 16'h0;
        ram[0] = 16'hA5A5;

        //         rst   wr     rdy   chk   ren   raddr vld   data        rd     av
        tbl[0] = '{1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd0, 6'd0};
        tbl[1] = '{1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd0, 6'd0};
        tbl[2] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd0, 6'd0};
        tbl[3] = '{1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 5'd0, 6'd1};
        tbl[4] = '{1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd1, 6'd1};
        tbl[5] = '{1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 16'hA5A5, 5'd1, 6'd1};
        tbl[6] = '{1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd1, 6'd0};

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; wr_ptr = tbl[i].wr; out_ready = tbl[i].rdy;
            #1;
            if (tbl[i].chk) begin
                chk($sformatf("v%0d_ren", i), 32'(mem_ren), 32'(tbl[i].ren));
                chk($sformatf("v%0d_vld", i), 32'(out_valid), 32'(tbl[i].vld));
                chk($sformatf("v%0d_rd", i), 32'(rd_ptr), 32'(tbl[i].rd));
                chk($sformatf("v%0d_av", i), 32'(avail), 32'(tbl[i].av));
                if (tbl[i].ren)
                    chk($sformatf("v%0d_raddr", i), 32'(mem_raddr), 32'(tbl[i].raddr));
                if (tbl[i].vld)
                    chk($sformatf("v%0d_data", i), 32'(out_data), 32'(tbl[i].data));
            end
            @(posedge clk);
            #1;
        end

        // Streaming: 16 words, back-to-back delivery
        rst = 1'b1; wr_ptr = 5'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) write_word(16'(i + 1));
        pops = 0;
        for (int i = 0; i < 40 && pops < 16; i++) tick();
        chk("stream_pops", 32'(pops), 32'd16);
        chk("stream_b2b", 32'(last_pop - first_pop), 32'd15);
        chk("stream_rd", 32'(rd_ptr), 32'd16);
        chk("stream_avail", 32'(avail), 32'd0);

        // Backpressure: 5 words, consumer stalled 6 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(16'hB000 + 16'(i));
        ren_cnt = 0; pops = 0; bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid && out_data !== 16'hB000) bad++;
        end
        chk("bp_ren_cnt", 32'(ren_cnt), 32'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'hB000);
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_avail", 32'(avail), 32'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && pops < 5; i++) tick();
        chk("bp_pops", 32'(pops), 32'd5);
        chk("bp_rd", 32'(rd_ptr), 32'd21);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Pointer wrap: park both pointers at 31 via flush
        wr_ptr = 5'd31; flush = 1'b1;
        #1;
        chk("flush_no_ren", 32'(mem_ren), 32'd0);
        tick();
        flush = 1'b0;
        chk("wrap_rd31", 32'(rd_ptr), 32'd31);
        chk("wrap_avail0", 32'(avail), 32'd0);
        raddr_log.delete(); rdp_log.delete(); pops = 0;
        for (int i = 0; i < 3; i++) write_word(16'hC001 + 16'(i));
        for (int i = 0; i < 20 && pops < 3; i++) tick();
        chk("wrap_pops", 32'(pops), 32'd3);
        chk("wrap_nren", 32'(raddr_log.size()), 32'd3);
        if (raddr_log.size() == 3 && rdp_log.size() == 3) begin
            chk("wrap_a0", 32'(raddr_log[0]), 32'd15);
            chk("wrap_a1", 32'(raddr_log[1]), 32'd0);
            chk("wrap_a2", 32'(raddr_log[2]), 32'd1);
            chk("wrap_p0", 32'(rdp_log[0]), 32'd31);
            chk("wrap_p1", 32'(rdp_log[1]), 32'd0);
            chk("wrap_p2", 32'(rdp_log[2]), 32'd1);
        end
        chk("wrap_rd2", 32'(rd_ptr), 32'd2);

        // Flush with one word buffered and one inflight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(16'hD001 + 16'(i));
        tick();
        tick();
        chk("fl_pre_avail", 32'(avail), 32'd4);
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_no_ren", 32'(mem_ren), 32'd0);
        sb.delete();
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_rd", 32'(rd_ptr), 32'd6);
        chk("fl_avail", 32'(avail), 32'd0);
        out_ready = 1'b1; bad = 0; ren_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) bad++;
        end
        chk("fl_quiet", 32'(bad), 32'd0);
        chk("fl_quiet_ren", 32'(ren_cnt), 32'd0);

        // Reset asserted together with flush
        out_ready = 1'b0;
        write_word(16'hE001);
        write_word(16'hE002);
        tick();
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        chk("rf_rd", 32'(rd_ptr), 32'd0);
        chk("rf_valid", 32'(out_valid), 32'd0);
        chk("rf_data", 32'(out_data), 32'd0);
        chk("rf_avail", 32'(avail), 32'd8);
        chk("rf_ren", 32'(mem_ren), 32'd0);
        rst = 1'b0; flush = 1'b0; wr_ptr = 5'd0;
        sb.delete();
        tick();
        chk("rf_post_avail", 32'(avail), 32'd0);
        chk("rf_post_ren", 32'(mem_ren), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
